// File: rtl/bus_arbiter_if.sv
// Requester handshakes and memory-bus control signals shared by bus_arbiter and its environment.
// master: the arbiter side (drives the memory bus, answers requesters); slave: requesters and memories.
interface bus_arbiter_if;
    logic        m0_req;
    logic        m0_rd;
    logic [15:0] m0_addr;
    logic [15:0] m0_wdata;
    logic [15:0] m0_rdata;
    logic        m0_ack;
    logic        m0_err;

    logic        m1_req;
    logic        m1_rd;
    logic [15:0] m1_addr;
    logic [15:0] m1_wdata;
    logic [15:0] m1_rdata;
    logic        m1_ack;
    logic        m1_err;

    logic [15:0] address;
    logic        read;
    logic        cs_rom;
    logic        cs_ram;
    logic        cs_gpr;
    logic        cs_ext_mem;
    logic        ready_rom;
    logic        ready_ram;
    logic        ready_gpr;
    logic        ready_ext_mem;
    logic        grant;
    logic        busy;

    modport master (
        input  m0_req, m0_rd, m0_addr, m0_wdata,
        output m0_rdata, m0_ack, m0_err,
        input  m1_req, m1_rd, m1_addr, m1_wdata,
        output m1_rdata, m1_ack, m1_err,
        output address, read, cs_rom, cs_ram, cs_gpr, cs_ext_mem,
        input  ready_rom, ready_ram, ready_gpr, ready_ext_mem,
        output grant, busy
    );

    modport slave (
        output m0_req, m0_rd, m0_addr, m0_wdata,
        input  m0_rdata, m0_ack, m0_err,
        output m1_req, m1_rd, m1_addr, m1_wdata,
        input  m1_rdata, m1_ack, m1_err,
        input  address, read, cs_rom, cs_ram, cs_gpr, cs_ext_mem,
        output ready_rom, ready_ram, ready_gpr, ready_ext_mem,
        input  grant, busy
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the MCU memory bus: address decode to one chip select,
// ready wait with timeout abort, read-data return and a one-cycle ack per transfer.
module bus_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic               clk,
    input  logic               reset,
    bus_arbiter_if.master      bus,
    inout  wire  [15:0]        data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [15:0]       rdata_q, rdata_d;

    logic [1:0]        sel;
    logic [3:0]        ready_vec;
    logic [3:0]        cs_vec;
    logic              in_access;
    logic              in_done;

    assign sel       = addr_q[15:14];
    assign in_access = (state_q == ACCESS);
    assign in_done   = (state_q == DONE);
    assign ready_vec = {bus.ready_ext_mem, bus.ready_gpr, bus.ready_ram, bus.ready_rom};
    assign cs_vec    = in_access ? (4'b0001 << sel) : 4'b0000;

    always_comb begin
        // NOTE: every next-state signal takes its held value first, so no path through this block infers a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        rdata_d      = rdata_q;

        unique case (state_q)
            IDLE: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                rdata_d = '0;
                if (bus.m0_req || bus.m1_req) begin
                    // On a tie the master that did not own the last transfer wins.
                    grant_d = (bus.m0_req && bus.m1_req) ? ~last_grant_q : bus.m1_req;
                    addr_d  = grant_d ? bus.m1_addr  : bus.m0_addr;
                    wdata_d = grant_d ? bus.m1_wdata : bus.m0_wdata;
                    rd_d    = grant_d ? bus.m1_rd    : bus.m0_rd;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (ready_vec[sel]) begin
                    if (rd_q) begin
                        rdata_d = data;
                    end
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            DONE: begin
                last_grant_d = grant_q;
                rdata_d      = '0;
                err_d        = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= 1'b1;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    assign bus.address    = addr_q;
    assign bus.read       = in_access ? rd_q : 1'b1;
    assign bus.cs_rom     = cs_vec[0];
    assign bus.cs_ram     = cs_vec[1];
    assign bus.cs_gpr     = cs_vec[2];
    assign bus.cs_ext_mem = cs_vec[3];
    assign bus.grant      = grant_q;
    assign bus.busy       = (state_q != IDLE);

    assign data = (in_access && !rd_q) ? wdata_q : 16'hzzzz;

    // Completion outputs exist only in DONE and only toward the granted master.
    assign bus.m0_ack   = in_done && !grant_q;
    assign bus.m1_ack   = in_done && grant_q;
    assign bus.m0_err   = bus.m0_ack && err_q;
    assign bus.m1_err   = bus.m1_ack && err_q;
    assign bus.m0_rdata = bus.m0_ack ? rdata_q : 16'h0000;
    assign bus.m1_rdata = bus.m1_ack ? rdata_q : 16'h0000;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: transaction-level reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_bus_arbiter;

    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bus_arbiter_if bus_if();
    wire [15:0] data;

    bus_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .data  (data)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave environment: each memory raises ready once it has been selected for w_cfg cycles.
    int          w_cfg [4];
    logic [15:0] s_val [4];
    bit          noise = 1'b0;
    int          acc_cnt = 0;
    wire [3:0]   cs_vec_tb = {bus_if.cs_ext_mem, bus_if.cs_gpr, bus_if.cs_ram, bus_if.cs_rom};

    always @(posedge clk) acc_cnt <= (|cs_vec_tb) ? acc_cnt + 1 : 0;

    assign bus_if.ready_rom     = bus_if.cs_rom     ? (acc_cnt >= w_cfg[0]) : noise;
    assign bus_if.ready_ram     = bus_if.cs_ram     ? (acc_cnt >= w_cfg[1]) : noise;
    assign bus_if.ready_gpr     = bus_if.cs_gpr     ? (acc_cnt >= w_cfg[2]) : noise;
    assign bus_if.ready_ext_mem = bus_if.cs_ext_mem ? (acc_cnt >= w_cfg[3]) : noise;

    // Reference model: one transfer record; its select length is min(wait+1, TIMEOUT), then one ack cycle.
    bit          mb = 1'b0;
    bit          mo = 1'b0;
    bit          mg = 1'b0;
    bit          mlast = 1'b1;
    bit          mr = 1'b1;
    bit          merr = 1'b0;
    logic [15:0] ma = '0;
    logic [15:0] mw = '0;
    logic [15:0] mv = '0;
    int          mk = 0;
    int          mlen = 0;

    wire m_acc = mb && (mk < mlen);
    wire m_done = mb && (mk == mlen);
    wire tb_drv = !(m_acc && !mr);
    wire [15:0] tb_val = (m_acc && mr) ? mv : 16'h0000;
    assign data = tb_drv ? tb_val : 16'hzzzz;

    always @(posedge clk) begin : model
        bit          o;
        int          w;
        logic [15:0] a;
        if (reset) begin
            mb    <= 1'b0;
            mg    <= 1'b0;
            mlast <= 1'b1;
            ma    <= '0;
            mk    <= 0;
        end else if (!mb) begin
            if (bus_if.m0_req || bus_if.m1_req) begin
                o = (bus_if.m0_req && bus_if.m1_req) ? !mlast : bus_if.m1_req;
                a = o ? bus_if.m1_addr : bus_if.m0_addr;
                w = w_cfg[a[15:14]];
                mb   <= 1'b1;
                mo   <= o;
                mg   <= o;
                ma   <= a;
                mr   <= o ? bus_if.m1_rd : bus_if.m0_rd;
                mw   <= o ? bus_if.m1_wdata : bus_if.m0_wdata;
                mv   <= s_val[a[15:14]];
                mk   <= 0;
                mlen <= (w >= TIMEOUT) ? TIMEOUT : w + 1;
                merr <= (w >= TIMEOUT);
            end
        end else begin
            if (mk == mlen) begin
                mb    <= 1'b0;
                mlast <= mo;
            end
            mk <= mk + 1;
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin : compare
        logic [3:0] exp_cs;
        if (cmp_en) begin
            exp_cs = m_acc ? (4'b0001 << ma[15:14]) : 4'b0000;
            check("cs", cs_vec_tb, exp_cs);
            check("read", bus_if.read, m_acc ? mr : 1'b1);
            check("address", bus_if.address, ma);
            check("busy", bus_if.busy, mb);
            check("grant", bus_if.grant, mg);
            check("m0_ack", bus_if.m0_ack, m_done && !mo);
            check("m1_ack", bus_if.m1_ack, m_done && mo);
            check("m0_err", bus_if.m0_err, m_done && !mo && merr);
            check("m1_err", bus_if.m1_err, m_done && mo && merr);
            check("m0_rdata", bus_if.m0_rdata, (m_done && !mo && mr && !merr) ? mv : 16'h0000);
            check("m1_rdata", bus_if.m1_rdata, (m_done && mo && mr && !merr) ? mv : 16'h0000);
            check("data", data, (m_acc && !mr) ? mw : tb_val);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input int m, input bit rd, input logic [15:0] addr, input logic [15:0] wd);
        if (m == 0) begin
            bus_if.m0_req = 1'b1; bus_if.m0_rd = rd; bus_if.m0_addr = addr; bus_if.m0_wdata = wd;
        end else begin
            bus_if.m1_req = 1'b1; bus_if.m1_rd = rd; bus_if.m1_addr = addr; bus_if.m1_wdata = wd;
        end
    endtask

    // Waits (bounded) for master m's ack, counting cycles with chip select csi high, then drops its req.
    task automatic txn_wait(input int m, input int csi, output int ncs, output logic [3:0] seen,
                            output logic [15:0] rd, output bit er, output bit g);
        bit ok;
        ok = 1'b0; ncs = 0; seen = '0; rd = '0; er = 1'b0; g = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (cs_vec_tb[csi]) ncs++;
            if (cs_vec_tb != 4'b0000) seen = cs_vec_tb;
            if ((m == 0 && bus_if.m0_ack) || (m == 1 && bus_if.m1_ack)) begin
                ok = 1'b1;
                rd = (m == 0) ? bus_if.m0_rdata : bus_if.m1_rdata;
                er = (m == 0) ? bus_if.m0_err : bus_if.m1_err;
                g  = bus_if.grant;
                break;
            end
        end
        check($sformatf("ack_seen_m%0d", m), ok, 1'b1);
        @(posedge clk); #1;
        if (m == 0) bus_if.m0_req = 1'b0; else bus_if.m1_req = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    int          ncs;
    logic [3:0]  seen;
    logic [15:0] rdv;
    bit          er;
    bit          g;
    int          gq [4];
    int          n;

    initial begin
        bus_if.m0_req = 1'b0; bus_if.m0_rd = 1'b1; bus_if.m0_addr = '0; bus_if.m0_wdata = '0;
        bus_if.m1_req = 1'b0; bus_if.m1_rd = 1'b1; bus_if.m1_addr = '0; bus_if.m1_wdata = '0;
        for (int i = 0; i < 4; i++) w_cfg[i] = 0;
        s_val[0] = 16'hA001; s_val[1] = 16'hBEEF; s_val[2] = 16'h5A5A; s_val[3] = 16'hC3C3;

        tick(2);
        cmp_en = 1'b1;
        tick(1);
        check("rst_busy", bus_if.busy, 1'b0);
        check("rst_read", bus_if.read, 1'b1);
        check("rst_addr", bus_if.address, 16'h0000);
        check("rst_cs", cs_vec_tb, 4'b0000);
        check("rst_grant", bus_if.grant, 1'b0);
        reset = 1'b0;

        // 1: zero-wait ram read for m0, with unselected readys held high
        noise = 1'b1;
        start(0, 1'b1, 16'h4010, 16'h0F0F);
        txn_wait(0, 1, ncs, seen, rdv, er, g);
        check("t1_cs_ram_cycles", ncs, 1);
        check("t1_rdata", rdv, 16'hBEEF);
        check("t1_err", er, 1'b0);

        // 6: decode sweep
        for (int i = 0; i < 4; i++) begin
            logic [15:0] a;
            a = {i[1:0], 14'h0000};
            start(0, 1'b1, a, 16'h0F0F);
            txn_wait(0, i, ncs, seen, rdv, er, g);
            check($sformatf("t6_cs_%0d", i), seen, 4'b0001 << i);
            check($sformatf("t6_rdata_%0d", i), rdv, s_val[i]);
        end
        noise = 1'b0;

        // 2: persistent simultaneous requests alternate starting with m0
        pulse_reset();
        start(0, 1'b1, 16'h0010, 16'h0F0F);
        start(1, 1'b1, 16'h4020, 16'hF0F0);
        n = 0;
        for (int c = 0; c < 80 && n < 4; c++) begin
            @(negedge clk);
            if (bus_if.m0_ack) begin gq[n] = 0; n++; end
            else if (bus_if.m1_ack) begin gq[n] = 1; n++; end
        end
        @(posedge clk); #1;
        bus_if.m0_req = 1'b0; bus_if.m1_req = 1'b0;
        check("t2_acks", n, 4);
        for (int i = 0; i < 4; i++) check($sformatf("t2_grant%0d", i), gq[i], i % 2);

        // 3: m1 write to ext_mem with three wait cycles
        w_cfg[3] = 3;
        start(1, 1'b0, 16'hC002, 16'h1234);
        txn_wait(1, 3, ncs, seen, rdv, er, g);
        check("t3_cs_ext_cycles", ncs, 4);
        check("t3_err", er, 1'b0);
        check("t3_rdata", rdv, 16'h0000);

        // 4: gpr never ready -> timeout abort, then a normal access
        w_cfg[2] = 99;
        start(0, 1'b1, 16'h8000, 16'h0F0F);
        txn_wait(0, 2, ncs, seen, rdv, er, g);
        check("t4_cs_gpr_cycles", ncs, TIMEOUT);
        check("t4_err", er, 1'b1);
        check("t4_rdata", rdv, 16'h0000);
        w_cfg[2] = 0;
        start(0, 1'b1, 16'h8002, 16'h0F0F);
        txn_wait(0, 2, ncs, seen, rdv, er, g);
        check("t4_next_err", er, 1'b0);
        check("t4_next_rdata", rdv, 16'h5A5A);

        // 5: reset in the middle of an m1 access; m0 then wins the tie
        w_cfg[3] = 99;
        start(1, 1'b1, 16'hC000, 16'h0F0F);
        tick(4);
        check("t5_pre_busy", bus_if.busy, 1'b1);
        reset = 1'b1;
        w_cfg[3] = 2;
        start(0, 1'b1, 16'h0100, 16'h0F0F);
        @(posedge clk);
        @(negedge clk);
        check("t5_busy", bus_if.busy, 1'b0);
        check("t5_cs", cs_vec_tb, 4'b0000);
        check("t5_m1_ack", bus_if.m1_ack, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        txn_wait(0, 0, ncs, seen, rdv, er, g);
        check("t5_first_grant", g, 1'b0);
        check("t5_m0_rdata", rdv, 16'hA001);
        txn_wait(1, 3, ncs, seen, rdv, er, g);
        check("t5_m1_grant", g, 1'b1);
        check("t5_m1_rdata", rdv, 16'hC3C3);

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
